// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: source count, FSM state
// codes and the fixed-priority encoder (bit 0 has the highest priority).
package irq_pkg;

    localparam int NUM_IRQ = 4;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_TAKE = 2'd2;
    localparam logic [1:0] ST_SERVICE   = 2'd3;

    typedef struct packed {
        logic               found;
        logic [1:0]         idx;
        logic [NUM_IRQ-1:0] onehot;
    } prio_t;

    // Scans from the top down so the lowest set bit is the last one written.
    function automatic prio_t prio_enc(input logic [NUM_IRQ-1:0] req);
        prio_t r;
        r = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                r.found     = 1'b1;
                r.idx       = i[1:0];
                r.onehot    = '0;
                r.onehot[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// One interrupt source: optional 2-flop synchroniser (IRQ_SYNC_EN) followed by
// a rising-edge detector. o_edge is a single-cycle pulse per rising edge.
module irq_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_irq,
    output logic o_edge
);

    logic w_level;
    logic r_prev;

`ifdef IRQ_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_irq;
            r_sync2 <= r_sync1;
        end
    end

    assign w_level = r_sync2;
`else
    assign w_level = i_irq;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_edge = w_level & ~r_prev;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge-captured pending bits, software mask, and a
// one-in-flight issue/take/return FSM. IRQ_SYNC_EN enables input synchronisers.
module irq_controller
    import irq_pkg::prio_t, irq_pkg::prio_enc, irq_pkg::ST_IDLE, irq_pkg::ST_ISSUE,
           irq_pkg::ST_WAIT_TAKE, irq_pkg::ST_SERVICE;
#(
    parameter int                 NUM_IRQ    = 4,
    parameter logic [NUM_IRQ-1:0] MASK_RESET = 4'b1111
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic               mask_wr,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               int_taken,
    input  logic               rti,
    output logic [NUM_IRQ-1:0] interrupts,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] in_service,
    output logic [NUM_IRQ-1:0] mask,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [1:0]         r_sel;
    logic               r_busy;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_interrupts;
    logic [NUM_IRQ-1:0] r_in_service;
    logic [NUM_IRQ-1:0] w_edges;
    logic [NUM_IRQ-1:0] w_clr;
    prio_t              w_win;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_src
        irq_sync u_sync (
            .i_clk   (clk),
            .i_rst_n (reset),
            .i_irq   (irq_src[g]),
            .o_edge  (w_edges[g])
        );
    end

    // Handshake: interrupts pulses for the single ISSUE cycle; fetch answers with
    // int_taken (accepted only in WAIT_TAKE) and later rti (accepted only in SERVICE).
    always_comb begin
        w_win        = prio_enc(r_pending & r_mask);
        w_next_state = r_state;
        w_clr        = '0;
        case (r_state)
            ST_IDLE:      if (w_win.found) w_next_state = ST_ISSUE;
            ST_ISSUE: begin
                w_next_state = ST_WAIT_TAKE;
                w_clr[r_sel] = 1'b1;
            end
            ST_WAIT_TAKE: if (int_taken) w_next_state = ST_SERVICE;
            ST_SERVICE:   if (rti) w_next_state = ST_IDLE;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_sel        <= '0;
            r_pending    <= '0;
            r_mask       <= MASK_RESET;
            r_interrupts <= '0;
            r_in_service <= '0;
        end else begin
            r_state      <= w_next_state;
            r_busy       <= (w_next_state != ST_IDLE);
            // A fresh edge on the source being cleared wins over the clear.
            r_pending    <= (r_pending & ~w_clr) | w_edges;
            r_interrupts <= '0;
            if (mask_wr) begin
                r_mask <= mask_wdata;
            end
            if (r_state == ST_IDLE && w_win.found) begin
                r_sel        <= w_win.idx;
                r_interrupts <= w_win.onehot;
                r_in_service <= w_win.onehot;
            end else if (r_state == ST_SERVICE && rti) begin
                r_in_service <= '0;
            end
        end
    end

    assign interrupts = r_interrupts;
    assign pending    = r_pending;
    assign in_service = r_in_service;
    assign mask       = r_mask;
    assign busy       = r_busy;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus random
// stimulus, each cycle compared against a behavioural model of the controller.
module tb_irq_controller;
    import irq_pkg::*;

    localparam int PH_IDLE    = 0;
    localparam int PH_ISSUE   = 1;
    localparam int PH_WAIT    = 2;
    localparam int PH_SERVICE = 3;

    logic       clk;
    logic       reset;
    logic [3:0] irq_src;
    logic       mask_wr;
    logic [3:0] mask_wdata;
    logic       int_taken;
    logic       rti;
    logic [3:0] interrupts;
    logic [3:0] pending;
    logic [3:0] in_service;
    logic [3:0] mask;
    logic       busy;
    logic [1:0] dbg_state;

    int n_vec;
    int n_fail;

    // Behavioural model state
    int       m_phase;
    int       m_sel;
    bit [3:0] m_pending;
    bit [3:0] m_mask;
    bit [3:0] m_insvc;
    bit [3:0] m_irq;
    bit [3:0] m_prev;
    bit [3:0] m_s1;
    bit [3:0] m_s2;
    logic [3:0] last_irq;

    irq_controller dut (
        .clk        (clk),
        .reset      (reset),
        .irq_src    (irq_src),
        .mask_wr    (mask_wr),
        .mask_wdata (mask_wdata),
        .int_taken  (int_taken),
        .rti        (rti),
        .interrupts (interrupts),
        .pending    (pending),
        .in_service (in_service),
        .mask       (mask),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b, expected %b", tag, $time, act, exp);
        end
    endtask

    function automatic int lowest(input bit [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [1:0] phase_code(input int ph);
        case (ph)
            PH_ISSUE:   return ST_ISSUE;
            PH_WAIT:    return ST_WAIT_TAKE;
            PH_SERVICE: return ST_SERVICE;
            default:    return ST_IDLE;
        endcase
    endfunction

    function automatic void model_reset();
        m_phase   = PH_IDLE;
        m_sel     = 0;
        m_pending = '0;
        m_mask    = 4'b1111;
        m_insvc   = '0;
        m_irq     = '0;
        m_prev    = '0;
        m_s1      = '0;
        m_s2      = '0;
    endfunction

    // Applies one clock edge worth of the controller's rules to the model.
    function automatic void model_edge();
        bit [3:0] lvl;
        bit [3:0] edges;
        bit [3:0] clr;
        bit [3:0] cand;
`ifdef IRQ_SYNC_EN
        lvl  = m_s2;
        m_s2 = m_s1;
        m_s1 = irq_src;
`else
        lvl  = irq_src;
`endif
        edges  = lvl & ~m_prev;
        m_prev = lvl;
        clr    = '0;
        m_irq  = '0;
        case (m_phase)
            PH_IDLE: begin
                cand = m_pending & m_mask;
                if (cand != 0) begin
                    m_sel        = lowest(cand);
                    m_irq[m_sel] = 1'b1;
                    m_insvc      = m_irq;
                    m_phase      = PH_ISSUE;
                end
            end
            PH_ISSUE: begin
                clr[m_sel] = 1'b1;
                m_phase    = PH_WAIT;
            end
            PH_WAIT: if (int_taken) m_phase = PH_SERVICE;
            default: if (rti) begin
                m_insvc = '0;
                m_phase = PH_IDLE;
            end
        endcase
        m_pending = (m_pending & ~clr) | edges;
        if (mask_wr) m_mask = mask_wdata;
    endfunction

    task automatic compare_all();
        check_val("interrupts", interrupts, m_irq);
        check_val("pending", pending, m_pending);
        check_val("in_service", in_service, m_insvc);
        check_val("mask", mask, m_mask);
        check_val("busy", {3'b0, busy}, {3'b0, (m_phase != PH_IDLE)});
        check_val("state", {2'b0, dbg_state}, {2'b0, phase_code(m_phase)});
        check_val("no_b2b_irq", {3'b0, (interrupts != 0 && last_irq != 0)}, 4'b0);
        last_irq = interrupts;
    endtask

    task automatic step(input logic [3:0] src, input logic tk, input logic r,
                        input logic mw, input logic [3:0] md);
        irq_src    = src;
        int_taken  = tk;
        rti        = r;
        mask_wr    = mw;
        mask_wdata = md;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n, input logic [3:0] src);
        for (int i = 0; i < n; i++) step(src, 1'b0, 1'b0, 1'b0, 4'b0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_mid();
        reset = 1'b0;
        #1;
        model_reset();
        last_irq = '0;
        compare_all();
        #1;
        reset = 1'b1;
    endtask

    initial begin
        n_vec      = 0;
        n_fail     = 0;
        last_irq   = '0;
        reset      = 1'b0;
        irq_src    = '0;
        mask_wr    = 1'b0;
        mask_wdata = '0;
        int_taken  = 1'b0;
        rti        = 1'b0;
        model_reset();
        #12;
        compare_all();
        reset = 1'b1;

        // Single source held high through take and return
        idle(2, 4'b0000);
        idle(5, 4'b0100);
        step(4'b0100, 1'b1, 1'b0, 1'b0, 4'b0);
        idle(3, 4'b0100);
        step(4'b0100, 1'b0, 1'b1, 1'b0, 4'b0);
        idle(3, 4'b0000);

        // Two simultaneous edges: bit 1 first, bit 3 right after its rti
        idle(4, 4'b1010);
        step(4'b1010, 1'b1, 1'b0, 1'b0, 4'b0);
        step(4'b1010, 1'b0, 1'b1, 1'b0, 4'b0);
        idle(2, 4'b1010);
        step(4'b1010, 1'b1, 1'b0, 1'b0, 4'b0);
        step(4'b1010, 1'b0, 1'b1, 1'b0, 4'b0);
        idle(2, 4'b0000);

        // Masked source stays pending until the mask is reopened
        step(4'b0000, 1'b0, 1'b0, 1'b1, 4'b1110);
        idle(4, 4'b0001);
        step(4'b0001, 1'b0, 1'b0, 1'b1, 4'b1111);
        idle(3, 4'b0001);
        step(4'b0001, 1'b1, 1'b0, 1'b0, 4'b0);
        step(4'b0001, 1'b0, 1'b1, 1'b0, 4'b0);
        idle(2, 4'b0000);

        // New edge on bit 2 exactly in its ISSUE cycle
        step(4'b0100, 1'b0, 1'b0, 1'b0, 4'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0);
        step(4'b0100, 1'b0, 1'b0, 1'b0, 4'b0);
        idle(2, 4'b0100);
        step(4'b0100, 1'b1, 1'b0, 1'b0, 4'b0);
        step(4'b0100, 1'b0, 1'b1, 1'b0, 4'b0);
        idle(3, 4'b0100);
        step(4'b0100, 1'b1, 1'b0, 1'b0, 4'b0);
        step(4'b0100, 1'b0, 1'b1, 1'b0, 4'b0);
        idle(2, 4'b0000);

        // Late int_taken with stray rti pulses while waiting
        idle(2, 4'b0010);
        for (int i = 0; i < 20; i++) step(4'b0010, 1'b0, (i % 5 == 2), 1'b0, 4'b0);
        step(4'b0010, 1'b1, 1'b0, 1'b0, 4'b0);
        step(4'b0010, 1'b0, 1'b1, 1'b0, 4'b0);
        idle(2, 4'b0000);

        // Reset while in SERVICE restores everything, mask included
        step(4'b0000, 1'b0, 1'b0, 1'b1, 4'b0110);
        idle(3, 4'b0010);
        step(4'b0010, 1'b1, 1'b0, 1'b0, 4'b0);
        idle(2, 4'b1011);
        reset_mid();
        idle(3, 4'b0000);

        // Random traffic
        begin
            logic [3:0] src;
            src = '0;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 3) == 0) src = 4'($urandom_range(0, 15));
                if (i == 700) reset_mid();
                step(src, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
